elev_req_arbiter: RTL and testbench
===================================

Name: elev_req_arbiter

Overview:
Upstream stage of the elevator floor controller. Synchronises and debounces the three hall/car call buttons and latches them as pending calls. It selects one target floor with a SCAN (keep-direction) policy and drives the controller's one-hot Req[3:1] input. It observes the controller's FLR1..3/Door outputs to learn the current floor and to retire calls once served.

Parameters:
DEB_CYCLES, 4, consecutive synchronised-high cycles required to accept a press (1..255)

Ports:
clk  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
Btn  input  [3:1]  raw asynchronous call buttons, bit n = floor n
FLR1  input  1  controller floor-1 indication
FLR2  input  1  controller floor-2 indication
FLR3  input  1  controller floor-3 indication
Door  input  1  controller door-open indication
Req  output  [3:1]  one-hot request to controller, or 3'b000; registered
Pending  output  [3:1]  call-lamp drive, bit n = outstanding call at floor n; registered

Behaviour:
- Reset (sampled at posedge): Req=000, Pending=000, FSM=IDLE, cur_floor=1, dir=UP, debouncers cleared and disarmed-free (ready to accept).
- Input path per button: 2-flop synchroniser, then counter. Counter increments while the synchronised level is 1 and saturates at DEB_CYCLES. It clears on any 0. Press is accepted once, on the cycle the counter reaches DEB_CYCLES. Re-arm only after the synchronised level returns to 0.
- Latency: Btn[n] sampled high at edges k..k+DEB_CYCLES+1 gives Pending[n]=1 after edge k+DEB_CYCLES+1. A pulse shorter than DEB_CYCLES synchronised cycles never sets Pending.
- cur_floor: updated from FLR1..3 only when exactly one of them is 1. Otherwise the last valid value is held.
- Retire: Pending[n] clears on any cycle with Door=1 and cur-floor indication FLRn=1. If an accepted press and a retire for the same floor occur in the same cycle, retire wins and Pending stays 0.
- FSM states: IDLE, SERVE, DOOR_WAIT.
- IDLE: Req=000. If Pending != 0, choose the target, load Req=onehot(target) on the next edge, and go to SERVE.
  - Priority 1: the current floor, if pending.
  - Priority 2: the nearest pending floor in direction dir.
  - Priority 3: otherwise reverse dir and take the nearest pending floor.
  - dir is set to UP/DOWN according to target vs cur_floor, and is unchanged if they are equal.
- SERVE: Req held stable (no re-targeting, even if a nearer call arrives). When Door=1 and FLR[target]=1: Req<=000, go to DOOR_WAIT.
- DOOR_WAIT: Req=000. When Door=0, go to IDLE. Req is never nonzero while Door=1 after service, so the controller does not reopen.
- Req invariant: $onehot0(Req) every cycle. Pending is never altered by target selection.
- Reset mid-operation: abandons target and pending calls. A button still held at reset is accepted only after it is released and re-pressed.
- Floors are fixed at 3, matching the controller's Req[3:1] width.

Decomposition:
- Shared package elev_pkg:
  - floor one-hot constants FLOOR1=3'b001, FLOOR2=3'b010, FLOOR3=3'b100
  - dir encoding UP=1'b1, DOWN=1'b0
  - arbiter FSM state encoding IDLE/SERVE/DOOR_WAIT
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, Reset, btn_raw, press_pulse), instantiated 3x. Selection, retire and FSM logic stay in the top.

Test Plan:
1. Assert Reset 2 cycles, Btn=000 -> Req=000, Pending=000, cur_floor=1, dir=UP; hold 20 cycles, outputs unchanged.
2. FLR1=1, Btn[2] high 10 cycles (DEB_CYCLES=4) -> Pending=010 after edge k+5, Req=010 after edge k+6. Model FLR2=1, Door=1 -> Pending=000 and Req=000 next edge; Door=0 -> IDLE.
3. Btn[3] high 3 cycles then low (DEB_CYCLES=4) -> Pending stays 000, Req stays 000. Bounce 1-0-1-1-1-1 -> exactly one acceptance.
4. cur_floor=2, dir=UP, Pending=101 accepted same cycle -> Req=100. After floor 3 is served, next Req=001 and dir=DOWN.
5. FLR1=1, Door=1, accepted press on floor 1 in the same cycle -> Pending[1]=0, no Req. Press on floor 3 during SERVE(target 2) -> Req stays 010, Pending=110.
6. Reset asserted while in SERVE with Req=100 and Btn[1] held -> next edge Req=000, Pending=000. Btn[1] ignored until released and re-pressed for 4 cycles.

Source files
------------

// File: rtl/elev_req_arbiter_pkg.sv
// Shared types and helpers for the elevator request arbiter: floor one-hots,
// travel direction, arbiter FSM states and the SCAN target picker.
package elev_pkg;

    localparam logic [3:1] FLOOR1 = 3'b001;
    localparam logic [3:1] FLOOR2 = 3'b010;
    localparam logic [3:1] FLOOR3 = 3'b100;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        DOOR_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [3:1] floor;
        dir_e       dir;
    } pick_t;

    function automatic logic [3:1] lowest_floor(logic [3:1] v);
        if (v[1])      return FLOOR1;
        else if (v[2]) return FLOOR2;
        else if (v[3]) return FLOOR3;
        else           return 3'b000;
    endfunction

    function automatic logic [3:1] highest_floor(logic [3:1] v);
        if (v[3])      return FLOOR3;
        else if (v[2]) return FLOOR2;
        else if (v[1]) return FLOOR1;
        else           return 3'b000;
    endfunction

    // One-hot floors order numerically, so plain compares give above/below.
    function automatic pick_t scan_pick(logic [3:1] pend, logic [3:1] cur, dir_e dir);
        pick_t      p;
        logic [3:1] above;
        logic [3:1] below;
        case (cur)
            FLOOR1:  begin above = pend & 3'b110; below = 3'b000;        end
            FLOOR2:  begin above = pend & 3'b100; below = pend & 3'b001; end
            default: begin above = 3'b000;        below = pend & 3'b011; end
        endcase
        p.dir = dir;
        if ((pend & cur) != 3'b000)
            p.floor = cur;
        else if (dir == UP)
            p.floor = (above != 3'b000) ? lowest_floor(above) : highest_floor(below);
        else
            p.floor = (below != 3'b000) ? highest_floor(below) : lowest_floor(above);
        if (p.floor != 3'b000 && p.floor > cur)
            p.dir = UP;
        else if (p.floor != 3'b000 && p.floor < cur)
            p.dir = DOWN;
        return p;
    endfunction

endpackage

// File: rtl/elev_req_arbiter_if.sv
// Signal bundle between the call buttons / floor controller and the arbiter.
interface elev_req_arbiter_if;

    // Protocol: Req is one-hot or zero. A nonzero Req is held unchanged until the
    // controller reports Door=1 with FLRn=1 for the requested floor; Req then drops
    // to zero and stays zero until the controller has closed the door (Door=0).
    logic [3:1] Btn;
    logic       FLR1;
    logic       FLR2;
    logic       FLR3;
    logic       Door;
    logic [3:1] Req;
    logic [3:1] Pending;

    modport master (
        output Btn, FLR1, FLR2, FLR3, Door,
        input  Req, Pending
    );

    modport slave (
        input  Btn, FLR1, FLR2, FLR3, Door,
        output Req, Pending
    );

endinterface

// File: rtl/elev_req_arbiter_btn_debounce.sv
// One call button: 2-flop synchroniser plus saturating debounce counter that
// emits a single-cycle press pulse per accepted press.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);

    logic [1:0] sync_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       armed_q;
    logic       armed_d;
    logic       lvl;

    assign lvl = sync_q[1];

    // Reset loads the synchroniser as "pressed" and disarms, so a button held
    // through reset must be seen released before it can be accepted again.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign press_pulse = lvl && armed_q && (cnt_q == DEB_MAX - 8'd1);

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!lvl) begin
            cnt_d   = 8'd0;
            armed_d = 1'b1;
        end else begin
            if (cnt_q != DEB_MAX)
                cnt_d = cnt_q + 8'd1;
            if (press_pulse)
                armed_d = 1'b0;
        end
    end

endmodule

// File: rtl/elev_req_arbiter.sv
// Elevator request arbiter: latches debounced calls, tracks the car floor and
// issues one-hot floor requests to the controller using a SCAN policy.
module elev_req_arbiter
    import elev_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               Reset,
    elev_req_arbiter_if.slave  bus,
    output arb_state_e         dbg_state_o,
    output logic [3:1]         dbg_floor_o,
    output dir_e               dbg_dir_o
);

    logic [3:1] press;
    logic [3:1] flr;
    logic [3:1] retire;
    logic [3:1] pending_q, pending_d;
    logic [3:1] floor_q, floor_d;
    logic [3:1] req_q, req_d;
    dir_e       dir_q, dir_d;
    arb_state_e state_q, state_d;
    pick_t      pick;
    logic       served;

    for (genvar n = 1; n <= 3; n++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk         (clk),
            .Reset       (Reset),
            .btn_raw     (bus.Btn[n]),
            .press_pulse (press[n])
        );
    end

    assign flr       = {bus.FLR3, bus.FLR2, bus.FLR1};
    assign retire    = flr & {3{bus.Door}};
    // Retire is applied after the press so a same-cycle press at an open floor is dropped.
    assign pending_d = (pending_q | press) & ~retire;
    assign floor_d   = $onehot(flr) ? flr : floor_q;
    assign pick      = scan_pick(pending_q, floor_q, dir_q);
    assign served    = bus.Door && ((flr & req_q) != 3'b000);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            req_q     <= 3'b000;
            pending_q <= 3'b000;
            floor_q   <= FLOOR1;
            dir_q     <= UP;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pending_q != 3'b000) state_d = SERVE;
            SERVE:     if (served)              state_d = DOOR_WAIT;
            DOOR_WAIT: if (!bus.Door)           state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d = req_q;
        dir_d = dir_q;
        case (state_q)
            IDLE: begin
                req_d = 3'b000;
                if (pending_q != 3'b000) begin
                    req_d = pick.floor;
                    dir_d = pick.dir;
                end
            end
            SERVE:   if (served) req_d = 3'b000;
            default: req_d = 3'b000;
        endcase
    end

    assign bus.Req     = req_q;
    assign bus.Pending = pending_q;
    assign dbg_state_o = state_q;
    assign dbg_floor_o = floor_q;
    assign dbg_dir_o   = dir_q;

endmodule

// File: tb/tb_elev_req_arbiter.sv
// Bench for elev_req_arbiter: directed call/serve scenarios followed by random
// buttons, a behavioural car controller and occasional resets.
module tb_elev_req_arbiter;
    import elev_pkg::*;

    localparam int DEB = 4;
    localparam int W   = 12;

    logic       clk;
    logic       Reset;
    arb_state_e dbg_state;
    logic [3:1] dbg_floor;
    dir_e       dbg_dir;

    int n_checks = 0;
    int n_fail   = 0;
    int car_floor = 1;

    logic [W-1:0] exp_q[$];
    logic [3:1]   hist[$];
    logic [3:1]   m_req, m_pend;
    int           m_floor, m_tgt, m_phase;
    bit           m_up;

    elev_req_arbiter_if bus ();

    elev_req_arbiter #(.DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_floor_o (dbg_floor),
        .dbg_dir_o   (dbg_dir)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:1] floor_bit(int f);
        logic [3:1] v = 3'b000;
        v[f] = 1'b1;
        return v;
    endfunction

    // DEB consecutive high samples preceded by a low seen since reset; the
    // synchroniser makes the newest usable sample the one from two edges ago.
    function automatic bit accepted(int n);
        int last  = hist.size() - 3;
        int first = last - DEB + 1;
        if (first < 1) return 1'b0;
        if (hist[first-1][n] != 1'b0) return 1'b0;
        for (int i = first; i <= last; i++)
            if (hist[i][n] != 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pick_target(logic [3:1] pend, int cur, bit up);
        int best  = 0;
        int bestd = 99;
        int d;
        if (pend[cur]) return cur;
        for (int f = 1; f <= 3; f++) begin
            d = (f > cur) ? f - cur : cur - f;
            if (pend[f] && ((up && f > cur) || (!up && f < cur)) && d < bestd) begin
                best = f; bestd = d;
            end
        end
        if (best == 0) begin
            for (int f = 1; f <= 3; f++) begin
                d = (f > cur) ? f - cur : cur - f;
                if (pend[f] && f != cur && d < bestd) begin
                    best = f; bestd = d;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step(logic rst, logic [3:1] btn, logic [3:1] flr, logic door);
        logic [3:1] acc;
        logic [3:1] new_pend;
        int         new_floor;
        if (rst) begin
            m_req = 3'b000; m_pend = 3'b000; m_floor = 1; m_up = 1'b1;
            m_phase = 0; m_tgt = 1;
            hist.delete();
        end else begin
            hist.push_back(btn);
            acc = 3'b000;
            for (int n = 1; n <= 3; n++) acc[n] = accepted(n);
            new_pend  = (m_pend | acc) & ~(door ? flr : 3'b000);
            new_floor = m_floor;
            if ($countones(flr) == 1)
                for (int f = 1; f <= 3; f++) if (flr[f]) new_floor = f;
            case (m_phase)
                0: if (m_pend != 3'b000) begin
                    m_tgt = pick_target(m_pend, m_floor, m_up);
                    m_req = floor_bit(m_tgt);
                    if (m_tgt > m_floor) m_up = 1'b1;
                    else if (m_tgt < m_floor) m_up = 1'b0;
                    m_phase = 1;
                end
                1: if (door && flr[m_tgt]) begin
                    m_req = 3'b000;
                    m_phase = 2;
                end
                default: if (!door) m_phase = 0;
            endcase
            m_pend  = new_pend;
            m_floor = new_floor;
        end
        exp_q.push_back({m_req, m_pend, floor_bit(m_floor), m_up, 2'(m_phase)});
    endtask

    // ---------------- scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        arb_state_e   es;
        forever begin
            @(posedge clk);
            model_step(Reset, bus.Btn, {bus.FLR3, bus.FLR2, bus.FLR1}, bus.Door);
            #1;
            e  = exp_q.pop_front();
            es = (e[1:0] == 2'd0) ? IDLE : ((e[1:0] == 2'd1) ? SERVE : DOOR_WAIT);
            check_eq("req",       32'(bus.Req),          32'(e[11:9]));
            check_eq("pending",   32'(bus.Pending),      32'(e[8:6]));
            check_eq("cur_floor", 32'(dbg_floor),        32'(e[5:3]));
            check_eq("dir",       32'(dbg_dir),          32'(e[2]));
            check_eq("state",     32'(dbg_state),        32'(es));
            check_eq("req_onehot0", 32'($onehot0(bus.Req)), 32'd1);
        end
    end

    // ---------------- drivers ----------------
    task automatic set_car(int f, logic door);
        bus.FLR1 = (f == 1);
        bus.FLR2 = (f == 2);
        bus.FLR3 = (f == 3);
        bus.Door = door;
    endtask

    task automatic check_outputs(string tag, logic [3:1] req, logic [3:1] pend);
        check_eq({tag, "_req"},  32'(bus.Req),     32'(req));
        check_eq({tag, "_pend"}, 32'(bus.Pending), 32'(pend));
    endtask

    task automatic ctrl_auto(int cycles);
        int st  = 0;
        int tmr = 0;
        int tgt = 1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            case (st)
                0: begin
                    if (bus.Req != 3'b000) begin
                        tgt = bus.Req[1] ? 1 : (bus.Req[2] ? 2 : 3);
                        if (tgt == car_floor) begin
                            set_car(car_floor, 1'b1); tmr = $urandom_range(2, 5); st = 2;
                        end else begin
                            set_car(0, 1'b0); tmr = $urandom_range(1, 3); st = 1;
                        end
                    end else if ($urandom_range(0, 30) == 0) begin
                        set_car(car_floor, 1'b1); tmr = $urandom_range(1, 3); st = 2;
                    end
                end
                1: begin
                    tmr--;
                    if (tmr == 0) begin
                        car_floor += (tgt > car_floor) ? 1 : -1;
                        set_car(car_floor, 1'b0);
                        st = (car_floor == tgt) ? 3 : 4;
                    end
                end
                2: begin
                    tmr--;
                    if (tmr == 0) begin set_car(car_floor, 1'b0); st = 0; end
                end
                3: begin set_car(car_floor, 1'b1); tmr = $urandom_range(2, 5); st = 2; end
                default: begin set_car(0, 1'b0); tmr = $urandom_range(1, 3); st = 1; end
            endcase
        end
    endtask

    task automatic btn_rand(int cycles);
        int left[3:1];
        for (int n = 1; n <= 3; n++) left[n] = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            for (int n = 1; n <= 3; n++) begin
                if (left[n] == 0) begin
                    bus.Btn[n] = ~bus.Btn[n];
                    left[n] = bus.Btn[n] ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 40));
                end else begin
                    left[n]--;
                end
            end
        end
    endtask

    task automatic rst_rand(int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            Reset = ($urandom_range(0, 400) == 0);
        end
        Reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] bounce;
        Reset   = 1'b1;
        bus.Btn = 3'b000;
        set_car(0, 1'b0);

        // reset state and quiet hold
        repeat (2) @(posedge clk);
        @(negedge clk) Reset = 1'b0;
        check_outputs("t1_reset", 3'b000, 3'b000);
        check_eq("t1_floor", 32'(dbg_floor), 32'(FLOOR1));
        check_eq("t1_dir",   32'(dbg_dir),   32'(UP));
        repeat (20) @(posedge clk);
        #1 check_outputs("t1_hold", 3'b000, 3'b000);

        // debounce latency and service of floor 2
        @(negedge clk);
        set_car(1, 1'b0);
        bus.Btn = 3'b010;
        repeat (5) @(posedge clk);
        #1 check_outputs("t2_early", 3'b000, 3'b000);
        @(posedge clk);
        #1 check_outputs("t2_accept", 3'b000, 3'b010);
        @(posedge clk);
        #1 check_outputs("t2_issue", 3'b010, 3'b010);
        repeat (3) @(negedge clk);
        bus.Btn = 3'b000;
        @(negedge clk) set_car(2, 1'b1);
        @(posedge clk);
        #1 check_outputs("t2_retire", 3'b000, 3'b000);
        @(negedge clk) set_car(2, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_outputs("t2_idle", 3'b000, 3'b000);

        // short pulse rejected, bounce accepted once
        @(negedge clk) bus.Btn = 3'b100;
        repeat (3) @(negedge clk);
        bus.Btn = 3'b000;
        repeat (10) @(posedge clk);
        #1 check_outputs("t3_short", 3'b000, 3'b000);
        bounce = 6'b111101;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) bus.Btn[3] = bounce[i];
        end
        @(negedge clk) bus.Btn = 3'b000;
        repeat (8) @(posedge clk);
        #1 check_outputs("t3_bounce", 3'b100, 3'b100);
        @(negedge clk) set_car(3, 1'b1);
        @(posedge clk);
        #1 check_outputs("t3_served", 3'b000, 3'b000);
        @(negedge clk) set_car(3, 1'b0);
        repeat (2) @(posedge clk);

        // SCAN: up first, then reverse
        @(negedge clk);
        set_car(2, 1'b0);
        bus.Btn = 3'b101;
        repeat (8) @(posedge clk);
        #1 check_outputs("t4_up", 3'b100, 3'b101);
        @(negedge clk);
        bus.Btn = 3'b000;
        set_car(3, 1'b1);
        @(posedge clk);
        #1 check_outputs("t4_served3", 3'b000, 3'b001);
        @(negedge clk) set_car(3, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_outputs("t4_reverse", 3'b001, 3'b001);
        check_eq("t4_dir", 32'(dbg_dir), 32'(DOWN));

        // press at open-door floor dropped; no re-targeting during SERVE
        @(negedge clk);
        set_car(1, 1'b1);
        bus.Btn = 3'b001;
        repeat (8) @(posedge clk);
        #1 check_outputs("t5_same_floor", 3'b000, 3'b000);
        @(negedge clk);
        bus.Btn = 3'b000;
        set_car(1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) bus.Btn = 3'b010;
        repeat (8) @(posedge clk);
        #1 check_outputs("t5_target2", 3'b010, 3'b010);
        @(negedge clk) bus.Btn = 3'b100;
        repeat (8) @(posedge clk);
        #1 check_outputs("t5_no_retarget", 3'b010, 3'b110);
        @(negedge clk) bus.Btn = 3'b000;

        // reset mid-service with a held button
        @(negedge clk) set_car(2, 1'b1);
        @(posedge clk);
        #1 check_outputs("t6_served2", 3'b000, 3'b100);
        @(negedge clk) set_car(2, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_outputs("t6_serve3", 3'b100, 3'b100);
        @(negedge clk) bus.Btn = 3'b001;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        @(posedge clk);
        #1 check_outputs("t6_reset", 3'b000, 3'b000);
        @(negedge clk) Reset = 1'b0;
        repeat (10) @(posedge clk);
        #1 check_eq("t6_held_pend", 32'(bus.Pending), 32'd0);
        @(negedge clk) bus.Btn = 3'b000;
        repeat (3) @(negedge clk);
        bus.Btn = 3'b001;
        repeat (8) @(posedge clk);
        #1 check_eq("t6_repress_pend", 32'(bus.Pending), 32'(3'b001));
        @(negedge clk) bus.Btn = 3'b000;
        car_floor = 2;

        // random traffic against the behavioural controller
        fork
            ctrl_auto(4000);
            btn_rand(3800);
            rst_rand(3800);
        join
        @(negedge clk);
        bus.Btn = 3'b000;
        Reset   = 1'b0;
        ctrl_auto(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
